// File: rtl/meissa_pkg.sv
// Shared defaults and FSM state encoding for the meissa accumulator slice.
package meissa_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int MAC_WIDTH_DEF   = DATA_WIDTH_DEF * 2;
  localparam int GUARD_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/meissa_sat.sv
// Reduces the guarded accumulator sum to MAC_WIDTH bits.
// MEISSA_ACC_SAT_EN selects clamping; otherwise the low bits pass through and o_sat is 0.
module meissa_sat
  import meissa_pkg::*;
#(
  parameter int MAC_WIDTH   = MAC_WIDTH_DEF,
  parameter int GUARD_WIDTH = GUARD_WIDTH_DEF
) (
  input  logic [MAC_WIDTH+GUARD_WIDTH-1:0] i_sum,
  output logic [MAC_WIDTH-1:0]             o_data,
  output logic                             o_sat
);

  localparam int ACC_WIDTH = MAC_WIDTH + GUARD_WIDTH;

`ifdef MEISSA_ACC_SAT_EN
  logic [GUARD_WIDTH:0] w_top;
  logic                 w_fits;

  // The sum fits when the guard bits are all copies of the MAC sign bit.
  assign w_top  = i_sum[ACC_WIDTH-1:MAC_WIDTH-1];
  assign w_fits = (w_top == '0) || (w_top == '1);

  always_comb begin
    o_data = i_sum[MAC_WIDTH-1:0];
    o_sat  = 1'b0;
    if (!w_fits) begin
      o_sat  = 1'b1;
      o_data = i_sum[ACC_WIDTH-1] ? {1'b1, {(MAC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(MAC_WIDTH-1){1'b1}}};
    end
  end
`else
  logic w_unused_guard;

  assign w_unused_guard = ^i_sum[ACC_WIDTH-1:MAC_WIDTH];
  assign o_data         = i_sum[MAC_WIDTH-1:0];
  assign o_sat          = 1'b0;
`endif

endmodule

// File: rtl/meissa_acc.sv
// Sums len signed PE products into a guarded accumulator and hands out one result.
// Optional clamping of the result is enabled by MEISSA_ACC_SAT_EN.
//
// state   | meaning
// IDLE    | waiting for start with len != 0
// ACC     | accepting products until len transfers have occurred
// DONE    | result held on out_data until out_ready
module meissa_acc
  import meissa_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MAC_WIDTH   = DATA_WIDTH * 2,
  parameter int GUARD_WIDTH = GUARD_WIDTH_DEF,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  input  logic [MAC_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [MAC_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int ACC_WIDTH = MAC_WIDTH + GUARD_WIDTH;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_acc_sum;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [LEN_WIDTH-1:0]   w_cnt_inc;
  logic                   w_accept_start;
  logic                   w_xfer;
  logic                   w_last;
  logic [MAC_WIDTH-1:0]   w_sat_data;
  logic                   w_sat_flag;

  assign w_acc_sum = r_acc + {{GUARD_WIDTH{in_data[MAC_WIDTH-1]}}, in_data};
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

  always_comb begin
    w_state_next   = r_state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    busy           = 1'b1;
    w_accept_start = 1'b0;
    w_xfer         = 1'b0;
    w_last         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && (len != '0)) begin
          w_accept_start = 1'b1;
          w_state_next   = ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_xfer = 1'b1;
          if (w_cnt_inc == r_len) begin
            w_last       = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_len <= len;
      end else if (w_xfer) begin
        r_acc <= w_acc_sum;
        r_cnt <= w_cnt_inc;
      end
      // Result is taken straight from the final sum so it is ready the next cycle.
      if (w_last) begin
        out_data <= w_sat_data;
        out_sat  <= w_sat_flag;
      end
    end
  end

  meissa_sat #(
    .MAC_WIDTH  (MAC_WIDTH),
    .GUARD_WIDTH(GUARD_WIDTH)
  ) u_sat (
    .i_sum (w_acc_sum),
    .o_data(w_sat_data),
    .o_sat (w_sat_flag)
  );

endmodule

// File: tb/tb_meissa_acc.sv
// Self-checking bench for meissa_acc; reference sums are kept as 64-bit integers.
module tb_meissa_acc;
  import meissa_pkg::*;

  localparam int MW = MAC_WIDTH_DEF;
  localparam int LW = LEN_WIDTH_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [MW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [MW-1:0] out_data;
  logic          out_ready;
  logic          out_sat;
  logic          busy;

  int     checks = 0;
  int     errors = 0;
  longint model_sum;

  always #5 clk = ~clk;

  meissa_acc dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  function automatic logic [MW-1:0] ref_data(input longint s);
    logic [63:0] u;
    u = s;
`ifdef MEISSA_ACC_SAT_EN
    if (s > ((longint'(1) << (MW-1)) - 1)) u = (longint'(1) << (MW-1)) - 1;
    else if (s < -(longint'(1) << (MW-1))) u = -(longint'(1) << (MW-1));
`endif
    return u[MW-1:0];
  endfunction

  function automatic logic ref_sat(input longint s);
`ifdef MEISSA_ACC_SAT_EN
    return (s > ((longint'(1) << (MW-1)) - 1)) || (s < -(longint'(1) << (MW-1)));
`else
    return (s != s);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_txn(input int n);
    start = 1'b1;
    len   = LW'(n);
    tick();
    start = 1'b0;
    model_sum = 0;
  endtask

  task automatic send(input logic [MW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid  = 1'b0;
    in_data   = MW'($urandom);
    model_sum = model_sum + longint'($signed(d));
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake_idle out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
        out_data !== '0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%b ir=%b busy=%b data=%h sat=%b required all 0",
               out_valid, in_ready, busy, out_data, out_sat);
    end
  endtask

  task automatic test_basic();
    begin_txn(3);
    send(MW'(5));
    send(MW'(-2));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid out_valid=%b required 0", out_valid);
    end
    send(MW'(7));
    checks++;
    if (out_valid !== 1'b1 || out_data !== MW'(10) || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result ov=%b data=%h sat=%b required 1 %h 0", out_valid, out_data,
               out_sat, MW'(10));
    end
    finish_txn();
  endtask

  task automatic test_gaps();
    begin_txn(4);
    for (int i = 0; i < 4; i++) begin
      send(MW'(1));
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gaps_ready in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
          end
          tick();
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== MW'(4)) begin
      errors++;
      $display("FAIL gaps_result ov=%b data=%h required 1 %h", out_valid, out_data, MW'(4));
    end
    finish_txn();
  endtask

  task automatic test_hold();
    logic [MW-1:0] exp_d;
    begin_txn(2);
    send(MW'($urandom));
    send(MW'($urandom));
    exp_d = ref_data(model_sum);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable k=%0d ov=%b data=%h ir=%b busy=%b required 1 %h 0 1",
                 k, out_valid, out_data, in_ready, busy, exp_d);
      end
      if (k == 2) begin start = 1'b1; len = LW'(3); end
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1; start = 1'b1; len = LW'(5);
    tick();
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release ov=%b busy=%b required 0 0", out_valid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored busy=%b ir=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_overflow();
    begin_txn(2);
    send(MW'(32'h7FFF_FFFF));
    send(MW'(32'h7FFF_FFFF));
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_data(model_sum) || out_sat !== ref_sat(model_sum)) begin
      errors++;
      $display("FAIL overflow ov=%b data=%h sat=%b required 1 %h %b", out_valid, out_data,
               out_sat, ref_data(model_sum), ref_sat(model_sum));
    end
    finish_txn();
  endtask

  task automatic test_reset_mid();
    begin_txn(4);
    send(MW'($urandom));
    send(MW'($urandom));
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre ov=%b busy=%b required 0 1", out_valid, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL midreset_post ov=%b busy=%b data=%h sat=%b required 0 0 0 0",
               out_valid, busy, out_data, out_sat);
    end
    begin_txn(1);
    send(MW'(-9));
    checks++;
    if (out_valid !== 1'b1 || out_data !== MW'(-9) || out_data !== ref_data(model_sum)) begin
      errors++;
      $display("FAIL midreset_result ov=%b data=%h required 1 %h", out_valid, out_data, MW'(-9));
    end
    finish_txn();
  endtask

  task automatic test_len0();
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle busy=%b ir=%b required 0 0", busy, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = MW'($urandom);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL len0_novalid ov=%b busy=%b required 0 0", out_valid, busy);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int            n;
    logic [MW-1:0] d;
    logic [MW-1:0] exp_d;
    logic          exp_s;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 12);
      begin_txn(n);
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          in_valid = 1'b0; in_data = MW'($urandom);
          tick();
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_acc t=%0d ir=%b ov=%b required 1 0", t, in_ready, out_valid);
        end
        if ($urandom_range(0, 1) == 0) d = MW'(int'($urandom_range(0, 2000)) - 1000);
        else                            d = MW'($urandom);
        send(d);
      end
      exp_d = ref_data(model_sum);
      exp_s = ref_sat(model_sum);
      for (int w = $urandom_range(0, 3); w >= 0; w--) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
          errors++;
          $display("FAIL rand_result t=%0d len=%0d ov=%b data=%h sat=%b required 1 %h %b",
                   t, n, out_valid, out_data, out_sat, exp_d, exp_s);
        end
        if (w > 0) tick();
      end
      finish_txn();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_overflow();
    test_reset_mid();
    test_len0();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
